// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding controller: mux select
// encodings, the in-flight stage record and the default register-id width.
package fwd_pkg;

  localparam int FWD_REG_AW = 3;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  is_load;
    logic [FWD_REG_AW-1:0] dst;
  } stage_t;

endpackage

// File: rtl/fwd_sel_ctrl_if.sv
// Decode-side bus of the forwarding controller: decode instr fields in,
// operand mux selects and load-use stall request out.
interface fwd_sel_ctrl_if #(
  parameter int REG_AW = 3
);
  logic              id_valid;
  logic              id_we;
  logic              id_is_load;
  logic [REG_AW-1:0] id_dst;
  logic [REG_AW-1:0] id_src0;
  logic [REG_AW-1:0] id_src1;
  logic              id_use0;
  logic              id_use1;
  logic [1:0]        src0_sel;
  logic [1:0]        src1_sel;
  logic              hazard_stall;

  modport master (
    output id_valid, id_we, id_is_load, id_dst, id_src0, id_src1, id_use0, id_use1,
    input  src0_sel, src1_sel, hazard_stall
  );

  modport slave (
    input  id_valid, id_we, id_is_load, id_dst, id_src0, id_src1, id_use0, id_use1,
    output src0_sel, src1_sel, hazard_stall
  );
endinterface

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding select: compares one source id against the EX, MEM
// and WB entries and picks the youngest matching producer.
module fwd_src_sel
  import fwd_pkg::*;
(
  input  logic                  src_use,
  input  logic [FWD_REG_AW-1:0] src,
  input  stage_t                ex,
  input  stage_t                mem,
  input  stage_t                wb,
  output logic [1:0]            sel,
  output logic                  ex_load_hit
);

  logic hit_ex, hit_mem, hit_wb;

  assign hit_ex  = src_use & ex.valid  & ex.we  & (ex.dst  == src);
  assign hit_mem = src_use & mem.valid & mem.we & (mem.dst == src);
  assign hit_wb  = src_use & wb.valid  & wb.we  & (wb.dst  == src);

  // A load in EX still selects EX; the stall keeps decode from consuming it.
  assign ex_load_hit = hit_ex & ex.is_load;

  always_comb begin
    sel = SEL_RF;
    if (hit_ex)       sel = SEL_EX;
    else if (hit_mem) sel = SEL_MEM;
    else if (hit_wb)  sel = SEL_WB;
  end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Operand-forwarding controller: tracks EX/MEM/WB destinations, drives mux4_32
// selects and requests a stall on load-use. Optional counters: FWD_STATS_EN.
module fwd_sel_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = FWD_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
`ifdef FWD_STATS_EN
  output logic [CNT_W-1:0] fwd_cnt,
  output logic [CNT_W-1:0] haz_cnt,
`endif
  fwd_sel_ctrl_if.slave    bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  stage_t ex_p0, mem_p1, wb_p2;
  logic   load_hit0, load_hit1;
  logic   accept;

  fwd_src_sel u_sel0 (
    .src_use     (bus.id_use0),
    .src         (bus.id_src0),
    .ex          (ex_p0),
    .mem         (mem_p1),
    .wb          (wb_p2),
    .sel         (bus.src0_sel),
    .ex_load_hit (load_hit0)
  );

  fwd_src_sel u_sel1 (
    .src_use     (bus.id_use1),
    .src         (bus.id_src1),
    .ex          (ex_p0),
    .mem         (mem_p1),
    .wb          (wb_p2),
    .sel         (bus.src1_sel),
    .ex_load_hit (load_hit1)
  );

  assign bus.hazard_stall = bus.id_valid & (load_hit0 | load_hit1);
  assign accept           = bus.id_valid & ~bus.hazard_stall;

  // ID -> EX (p0) -> MEM (p1) -> WB (p2); only the valid bits are reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_p0.valid  <= 1'b0;
      mem_p1.valid <= 1'b0;
      wb_p2.valid  <= 1'b0;
    end else if (flush) begin
      ex_p0.valid  <= 1'b0;
      mem_p1.valid <= 1'b0;
      if (!stall) wb_p2 <= mem_p1;
    end else if (!stall) begin
      wb_p2  <= mem_p1;
      mem_p1 <= ex_p0;
      ex_p0  <= '{valid: accept, we: bus.id_we, is_load: bus.id_is_load, dst: bus.id_dst};
    end
  end

`ifdef FWD_STATS_EN
  logic fwd_take;

  assign fwd_take = (bus.id_use0 & (bus.src0_sel != SEL_RF)) |
                    (bus.id_use1 & (bus.src1_sel != SEL_RF));

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt <= '0;
      haz_cnt <= '0;
    end else begin
      if (!stall && fwd_take) fwd_cnt <= sat_inc(fwd_cnt);
      if (bus.hazard_stall)   haz_cnt <= sat_inc(haz_cnt);
    end
  end
`endif

endmodule
